fetch_stage: RTL



---
 rtl/fetch_stage_pkg.sv | 19 +
 rtl/npc_calc.sv | 56 +++++
 rtl/fetch_stage.sv | 52 +++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: next-PC select codes and reset constants.
package fetch_stage_pkg;

  // nPC_sel codes driven by the main decoder for the instruction in D.
  localparam logic [3:0] NPC_PC4  = 4'd0;
  localparam logic [3:0] NPC_BEQ  = 4'd1;
  localparam logic [3:0] NPC_J    = 4'd2;
  localparam logic [3:0] NPC_JR   = 4'd3;
  localparam logic [3:0] NPC_BNE  = 4'd4;
  localparam logic [3:0] NPC_BGEZ = 4'd5;
  localparam logic [3:0] NPC_BGTZ = 4'd6;
  localparam logic [3:0] NPC_BLEZ = 4'd7;
  localparam logic [3:0] NPC_BLTZ = 4'd8;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_3000;
  // sll $0,$0,0
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection for the instruction currently in D.
module npc_calc
  import fetch_stage_pkg::*;
(
  input  logic [3:0]  npc_sel,
  input  logic [31:0] pc_f,
  input  logic [31:0] pc_d,
  input  logic [31:0] instr_d,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] npc,
  output logic        redirect
);

  logic [31:0] seq_pc;
  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic        rs_zero;
  logic        unused_opcode;

  // All adders wrap modulo 2^32.
  assign seq_pc  = pc_f + 32'd4;
  assign br_off  = {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
  assign br_tgt  = pc_d + 32'd4 + br_off;
  assign j_tgt   = {pc_d[31:28], instr_d[25:0], 2'b00};
  assign rs_zero = (rs == 32'd0);

  // Opcode is the decoder's business; only the target fields are used here.
  assign unused_opcode = ^instr_d[31:26];

  // Pick the next fetch address; redirect flags any non-sequential choice.
  always_comb begin
    npc      = seq_pc;
    redirect = 1'b0;
    case (npc_sel)
      NPC_BEQ:  redirect = (rs == rt);
      NPC_BNE:  redirect = (rs != rt);
      NPC_BGEZ: redirect = ~rs[31];
      NPC_BGTZ: redirect = ~rs[31] & ~rs_zero;
      NPC_BLEZ: redirect = rs[31] | rs_zero;
      NPC_BLTZ: redirect = rs[31];
      NPC_J:    redirect = 1'b1;
      NPC_JR:   redirect = 1'b1;
      default:  redirect = 1'b0;  // includes unused codes 9-15
    endcase
    if (redirect) begin
      case (npc_sel)
        NPC_J:   npc = j_tgt;
        NPC_JR:  npc = rs;  // no alignment masking
        default: npc = br_tgt;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Program counter, next-PC selection and IF/ID pipeline register.
// Branches resolve in D with one delay slot, so nothing is ever flushed.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [3:0]  npc_sel,
  input  logic [31:0] d_rs_val,
  input  logic [31:0] d_rt_val,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        redirect_d
);

  logic [31:0] npc;

  npc_calc u_npc_calc (
    .npc_sel  (npc_sel),
    .pc_f     (pc_f),
    .pc_d     (pc_d),
    .instr_d  (instr_d),
    .rs       (d_rs_val),
    .rt       (d_rt_val),
    .npc      (npc),
    .redirect (redirect_d)
  );

  // Link value for jal/jalr/bgezal/bltzal skips the delay slot.
  assign pc8_d = pc_d + 32'd8;

  // PC and IF/ID register; the delay-slot word is latched normally on a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f    <= RESET_PC;
      instr_d <= NOP_INSTR;
      pc_d    <= RESET_PC;
    end else if (!stall) begin
      pc_f    <= npc;
      instr_d <= imem_rdata;
      pc_d    <= pc_f;
    end
  end

endmodule
